multicycle_controller: RTL and testbench

Parametrised multi-cycle control unit for the RV64I core. It replaces single-cycle combinational decode with a state machine that sequences fetch, decode, execute, memory and writeback. It drives the same datapath select and enable signals, with valid/ack handshakes to instruction and data memory, a bus timeout, and a sticky trap state for illegal instructions and bus errors. It sits beside the datapath and decodes the instruction register, which the datapath loads on `ir_we`.

---
 rtl/multicycle_controller.sv | 160 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout and sticky trap for the RV64I core.
package CorePack;
  typedef logic [31:0] inst_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immgen_op_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW
  } alu_op_t;
  typedef enum logic [2:0] {CMP_NONE, CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU} cmp_op_t;
  typedef enum logic [1:0] {ASEL_REG, ASEL_PC, ASEL_ZERO} alu_asel_t;
  typedef enum logic {BSEL_REG, BSEL_IMM} alu_bsel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;
  typedef enum logic [2:0] {MEM_NONE, MEM_B, MEM_H, MEM_W, MEM_D, MEM_BU, MEM_HU, MEM_WU} mem_op_t;
endpackage

module multicycle_controller #(
  parameter int RV64    = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  CorePack::inst_t        inst,
  input  logic                   cmp_res,
  input  logic                   imem_ack,
  input  logic                   dmem_ack,
  output logic                   imem_req,
  output logic                   dmem_req,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic                   we_reg,
  output logic                   we_mem,
  output logic                   re_mem,
  output logic                   npc_sel,
  output CorePack::immgen_op_t   immgen_op,
  output CorePack::alu_op_t      alu_op,
  output CorePack::cmp_op_t      cmp_op,
  output CorePack::alu_asel_t    alu_asel,
  output CorePack::alu_bsel_t    alu_bsel,
  output CorePack::wb_sel_t      wb_sel,
  output CorePack::mem_op_t      mem_op,
  output logic                   illegal_inst,
  output logic                   bus_err,
  output logic                   halted
);
  import CorePack::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ill_q, ill_d, berr_q, berr_d;
  logic [6:0] opc;
  logic [2:0] f3;
  logic alt, unused_inst;
  logic is_op, is_opi, is_op32, is_opi32, is_lui, is_auipc, is_load, is_store, is_br, is_jal, is_jalr;
  logic is_w, is_jmp, is_arith, legal;
  logic waiting, ack, tmo;
  logic live, f_st, e_st, m_st, w_st, dp;
  alu_op_t alu_base;
  assign opc         = inst[6:0];
  assign f3          = inst[14:12];
  assign alt         = inst[30];
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};
  assign is_op    = opc == 7'b0110011;
  assign is_opi   = opc == 7'b0010011;
  assign is_op32  = opc == 7'b0111011;
  assign is_opi32 = opc == 7'b0011011;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_load  = opc == 7'b0000011;
  assign is_store = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_w     = is_op32 || is_opi32;
  assign is_jmp   = is_jal || is_jalr;
  assign is_arith = is_op || is_opi || is_w;
  assign legal    = is_op || is_opi || is_lui || is_auipc || is_load || is_store || is_br || is_jmp ||
                    (is_w && RV64 != 0);
  // One counter serves both wait states; an ack on the last allowed cycle still wins.
  assign waiting = state_q == FETCH || state_q == MEM;
  assign ack     = state_q == FETCH ? imem_ack : dmem_ack;
  assign tmo     = waiting && !ack && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    cnt_d  = (waiting && !ack) ? cnt_q + CW'(1) : '0;
    ill_d  = ill_q || (state_q == DECODE && !legal);
    berr_d = berr_q || tmo;
    case (state_q)
      FETCH:   state_d = imem_ack ? DECODE : tmo ? TRAP : FETCH;
      DECODE:  state_d = legal ? EXEC : TRAP;
      EXEC:    state_d = is_br ? FETCH : (is_load || is_store) ? MEM : WB;
      MEM:     state_d = dmem_ack ? (is_load ? WB : FETCH) : tmo ? TRAP : MEM;
      WB:      state_d = FETCH;
      default: state_d = TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end
  // Every output is masked while rst is high so reset can never leak a pulse.
  assign live = !rst;
  assign f_st = live && state_q == FETCH;
  assign e_st = live && state_q == EXEC;
  assign m_st = live && state_q == MEM;
  assign w_st = live && state_q == WB;
  assign dp   = live && state_q inside {DECODE, EXEC, MEM, WB};
  assign imem_req     = f_st;
  assign ir_we        = f_st && imem_ack;
  assign dmem_req     = m_st;
  assign re_mem       = m_st && is_load;
  assign we_mem       = m_st && is_store && dmem_ack;
  assign pc_we        = (e_st && is_br) || (m_st && is_store && dmem_ack) || w_st;
  assign npc_sel      = (e_st && is_br && cmp_res) || (w_st && is_jmp);
  assign we_reg       = w_st;
  assign illegal_inst = live && ill_q;
  assign bus_err      = live && berr_q;
  assign halted       = live && state_q == TRAP;
  always_comb begin
    case (f3)
      3'd0:    alu_base = ((is_op || is_op32) && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_base = ALU_SLL;
      3'd2:    alu_base = ALU_SLT;
      3'd3:    alu_base = ALU_SLTU;
      3'd4:    alu_base = ALU_XOR;
      3'd5:    alu_base = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  end
  always_comb begin
    immgen_op = IMM_NONE;
    alu_op    = ALU_ADD;
    cmp_op    = CMP_NONE;
    alu_asel  = ASEL_REG;
    alu_bsel  = BSEL_REG;
    wb_sel    = WB_ALU;
    mem_op    = MEM_NONE;
    if (dp) begin
      immgen_op = (is_opi || is_opi32 || is_load || is_jalr) ? IMM_I : is_store ? IMM_S : is_br ? IMM_B :
                  (is_lui || is_auipc) ? IMM_U : is_jal ? IMM_J : IMM_NONE;
      alu_op    = !is_arith ? ALU_ADD : !is_w ? alu_base : alu_base == ALU_SUB ? ALU_SUBW :
                  alu_base == ALU_SLL ? ALU_SLLW : alu_base == ALU_SRL ? ALU_SRLW :
                  alu_base == ALU_SRA ? ALU_SRAW : ALU_ADDW;
      cmp_op    = is_br ? cmp_op_t'(f3[2] ? {1'b0, f3[1:0]} + 3'd3 : {1'b0, f3[1:0]} + 3'd1) : CMP_NONE;
      alu_asel  = (is_auipc || is_jal || is_br) ? ASEL_PC : is_lui ? ASEL_ZERO : ASEL_REG;
      alu_bsel  = (is_op || is_op32) ? BSEL_REG : BSEL_IMM;
      wb_sel    = is_load ? WB_MEM : is_jmp ? WB_PC4 : is_lui ? WB_IMM : WB_ALU;
      mem_op    = (is_load || is_store) ? mem_op_t'(f3 + 3'd1) : MEM_NONE;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of sequencing, handshakes, timeout and trap behaviour.
module tb_multicycle_controller;
  import CorePack::*;
  localparam logic [10:0] O_IREQ = 11'h400, O_DREQ = 11'h200, O_IRWE = 11'h100, O_PCWE = 11'h080;
  localparam logic [10:0] O_WREG = 11'h040, O_WMEM = 11'h020, O_RMEM = 11'h010, O_NPC = 11'h008;
  localparam logic [10:0] O_ILL = 11'h004, O_BERR = 11'h002, O_HALT = 11'h001;
  localparam inst_t ADDI = 32'h00500093, LW = 32'h0000a103, SW = 32'h0020a223;
  localparam inst_t BEQ = 32'h00000463, JAL = 32'h010000ef, ADDIW = 32'h0000009b;
  logic clk = 1'b0;
  logic rst, cmp_res, imem_ack, dmem_ack;
  inst_t inst;
  logic imem_req, dmem_req, ir_we, pc_we, we_reg, we_mem, re_mem, npc_sel, illegal_inst, bus_err, halted;
  logic r_imem_req, r_dmem_req, r_ir_we, r_pc_we, r_we_reg, r_we_mem, r_re_mem, r_npc_sel;
  logic r_illegal_inst, r_bus_err, r_halted;
  immgen_op_t immgen_op, r_immgen_op;
  alu_op_t alu_op, r_alu_op;
  cmp_op_t cmp_op, r_cmp_op;
  alu_asel_t alu_asel, r_alu_asel;
  alu_bsel_t alu_bsel, r_alu_bsel;
  wb_sel_t wb_sel, r_wb_sel;
  mem_op_t mem_op, r_mem_op;
  logic [10:0] o, ro;
  logic [17:0] dpv;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  multicycle_controller #(.RV64(1), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .inst(inst), .cmp_res(cmp_res), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we), .we_reg(we_reg),
    .we_mem(we_mem), .re_mem(re_mem), .npc_sel(npc_sel), .immgen_op(immgen_op), .alu_op(alu_op),
    .cmp_op(cmp_op), .alu_asel(alu_asel), .alu_bsel(alu_bsel), .wb_sel(wb_sel), .mem_op(mem_op),
    .illegal_inst(illegal_inst), .bus_err(bus_err), .halted(halted));
  multicycle_controller #(.RV64(0), .TIMEOUT(4)) u_rv32 (
    .clk(clk), .rst(rst), .inst(inst), .cmp_res(cmp_res), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(r_imem_req), .dmem_req(r_dmem_req), .ir_we(r_ir_we), .pc_we(r_pc_we), .we_reg(r_we_reg),
    .we_mem(r_we_mem), .re_mem(r_re_mem), .npc_sel(r_npc_sel), .immgen_op(r_immgen_op), .alu_op(r_alu_op),
    .cmp_op(r_cmp_op), .alu_asel(r_alu_asel), .alu_bsel(r_alu_bsel), .wb_sel(r_wb_sel), .mem_op(r_mem_op),
    .illegal_inst(r_illegal_inst), .bus_err(r_bus_err), .halted(r_halted));
  assign o   = {imem_req, dmem_req, ir_we, pc_we, we_reg, we_mem, re_mem, npc_sel, illegal_inst, bus_err, halted};
  assign ro  = {r_imem_req, r_dmem_req, r_ir_we, r_pc_we, r_we_reg, r_we_mem, r_re_mem, r_npc_sel,
                r_illegal_inst, r_bus_err, r_halted};
  assign dpv = {immgen_op, alu_op, cmp_op, alu_asel, alu_bsel, wb_sel, mem_op};
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic fetch(input inst_t i);
    inst = i;
    imem_ack = 1'b1;
    #1;
    chk("fetch", 32'(o), 32'(O_IREQ | O_IRWE));
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("decode", 32'(o), 32'd0);
  endtask
  initial begin
    rst = 1'b1; inst = '0; cmp_res = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    cyc(); cyc();
    imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    chk("rst_out", 32'(o), 32'd0);
    chk("rst_dp", 32'(dpv), 32'd0);
    chk("rst_rv32", 32'(ro), 32'd0);
    cyc();
    rst = 1'b0; dmem_ack = 1'b0;
    fetch(ADDI);
    cyc(); #1;
    chk("addi_ex_o", 32'(o), 32'd0);
    chk("addi_ex_imm", 32'(immgen_op), 32'(IMM_I));
    chk("addi_ex_alu", 32'(alu_op), 32'(ALU_ADD));
    chk("addi_ex_bsel", 32'(alu_bsel), 32'(BSEL_IMM));
    chk("addi_ex_asel", 32'(alu_asel), 32'(ASEL_REG));
    cyc(); #1;
    chk("addi_wb_o", 32'(o), 32'(O_PCWE | O_WREG));
    chk("addi_wb_sel", 32'(wb_sel), 32'(WB_ALU));
    cyc(); #1;
    chk("addi_next", 32'(o), 32'(O_IREQ));
    fetch(LW);
    cyc(); #1;
    chk("lw_ex_imm", 32'(immgen_op), 32'(IMM_I));
    cyc();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      chk("lw_mem_o", 32'(o), 32'(O_DREQ | O_RMEM));
      chk("lw_mem_op", 32'(mem_op), 32'(MEM_W));
      cyc();
    end
    dmem_ack = 1'b0;
    #1;
    chk("lw_wb_o", 32'(o), 32'(O_PCWE | O_WREG));
    chk("lw_wb_sel", 32'(wb_sel), 32'(WB_MEM));
    cyc(); #1;
    chk("lw_next", 32'(o), 32'(O_IREQ));
    fetch(SW);
    cyc(); #1;
    chk("sw_ex_imm", 32'(immgen_op), 32'(IMM_S));
    cyc(); #1;
    chk("sw_wait", 32'(o), 32'(O_DREQ));
    cyc();
    dmem_ack = 1'b1;
    #1;
    chk("sw_ack", 32'(o), 32'(O_DREQ | O_WMEM | O_PCWE));
    chk("sw_mem_op", 32'(mem_op), 32'(MEM_W));
    cyc();
    dmem_ack = 1'b0;
    #1;
    chk("sw_next", 32'(o), 32'(O_IREQ));
    cmp_res = 1'b1;
    fetch(BEQ);
    cyc(); #1;
    chk("beq_t_o", 32'(o), 32'(O_PCWE | O_NPC));
    chk("beq_cmp", 32'(cmp_op), 32'(CMP_EQ));
    chk("beq_imm", 32'(immgen_op), 32'(IMM_B));
    cyc(); #1;
    chk("beq_t_next", 32'(o), 32'(O_IREQ));
    cmp_res = 1'b0;
    fetch(BEQ);
    cyc(); #1;
    chk("beq_nt_o", 32'(o), 32'(O_PCWE));
    cyc(); #1;
    chk("beq_nt_next", 32'(o), 32'(O_IREQ));
    fetch(JAL);
    cyc(); #1;
    chk("jal_imm", 32'(immgen_op), 32'(IMM_J));
    chk("jal_asel", 32'(alu_asel), 32'(ASEL_PC));
    cyc(); #1;
    chk("jal_wb_o", 32'(o), 32'(O_PCWE | O_WREG | O_NPC));
    chk("jal_wb_sel", 32'(wb_sel), 32'(WB_PC4));
    cyc(); #1;
    chk("jal_next", 32'(o), 32'(O_IREQ));
    fetch(SW);
    cyc(); cyc(); #1;
    chk("rmem_wait", 32'(o), 32'(O_DREQ));
    cyc();
    rst = 1'b1; dmem_ack = 1'b1;
    #1;
    chk("rmem_rst", 32'(o), 32'd0);
    cyc();
    rst = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("rmem_refetch", 32'(o), 32'(O_IREQ));
    fetch(32'h0);
    cyc(); #1;
    chk("ill_trap", 32'(o), 32'(O_ILL | O_HALT));
    imem_ack = 1'b1; dmem_ack = 1'b1; cmp_res = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk("ill_hold", 32'(o), 32'(O_ILL | O_HALT));
    end
    rst = 1'b1;
    #1;
    chk("ill_rst", 32'(o), 32'd0);
    cyc();
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("ill_cleared", 32'(o), 32'(O_IREQ));
    fetch(ADDIW);
    cyc(); #1;
    chk("addiw_rv32_trap", 32'(ro), 32'(O_ILL | O_HALT));
    chk("addiw_rv64_ex", 32'(o), 32'd0);
    chk("addiw_alu", 32'(alu_op), 32'(ALU_ADDW));
    cyc(); #1;
    chk("addiw_rv64_wb", 32'(o), 32'(O_PCWE | O_WREG));
    cyc(); #1;
    chk("addiw_rv32_hold", 32'(ro), 32'(O_ILL | O_HALT));
    rst = 1'b1;
    cyc();
    rst = 1'b0; inst = ADDI;
    #1;
    chk("to_rv32_cleared", 32'(ro), 32'(O_IREQ));
    for (int i = 0; i < 4; i++) begin
      chk("to_wait", 32'(o), 32'(O_IREQ));
      cyc();
    end
    chk("to_trap", 32'(o), 32'(O_BERR | O_HALT));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      #1;
      chk("to_edge_wait", 32'(o), 32'((i == 3) ? (O_IREQ | O_IRWE) : O_IREQ));
      cyc();
    end
    imem_ack = 1'b0;
    #1;
    chk("to_edge_decode", 32'(o), 32'd0);
    cyc(); #1;
    chk("to_edge_exec", 32'(immgen_op), 32'(IMM_I));
    chk("to_edge_nohalt", 32'(o), 32'd0);
    cyc(); cyc();
    fetch(LW);
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dto_wait", 32'(o), 32'(O_DREQ | O_RMEM));
      cyc();
    end
    #1;
    chk("dto_trap", 32'(o), 32'(O_BERR | O_HALT));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
